// File: rtl/mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_issue_ctrl
//  Purpose  : Operand FIFO and single-issue controller for the nibble-serial
//             32x32 multiplier; returns each product with its tag on a
//             valid/ready result port, strictly in push order.
//  Revision : 1.0
// ============================================================================
module mult_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       mul_valid_in,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    input  logic                       mul_valid_out,
    input  logic [63:0]                mul_r,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [63:0]                res_r,
    output logic [TAG_W-1:0]           res_tag,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    // ------------------------------------------------------------------
    // Operand FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [31:0]        r_mem_a   [DEPTH];
    logic [31:0]        r_mem_b   [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_mul_valid_in;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [TAG_W-1:0]   r_iss_tag;

    logic               r_res_valid;
    logic [63:0]        r_res_r;
    logic [TAG_W-1:0]   r_res_tag;

    logic               w_in_ready;
    logic               w_push;
    logic               w_issue;
    logic               w_capture;
    logic               w_res_take;

    // Ready comes only from the registered count: a full FIFO never accepts,
    // even when an issue frees a slot on the same edge.
    assign w_in_ready = (r_count != c_CNT_W'(DEPTH));
    assign w_push     = in_valid && w_in_ready;
    assign w_res_take = r_res_valid && res_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (mul_valid_out) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    // The result slot must be empty (or emptying) before issuing, so a
    // capture can never collide with a held result.
    always_comb begin
        w_issue   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_issue = (r_count != '0) && (!r_res_valid || res_ready);
            end
            c_ST_WAIT: begin
                w_capture = mul_valid_out;
            end
            default: begin
                w_issue   = 1'b0;
                w_capture = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier launch registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_valid_in <= 1'b0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_iss_tag      <= '0;
        end else begin
            r_mul_valid_in <= w_issue;
            if (w_issue) begin
                r_mul_a   <= r_mem_a[r_rd_ptr];
                r_mul_b   <= r_mem_b[r_rd_ptr];
                r_iss_tag <= r_mem_tag[r_rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_r     <= '0;
            r_res_tag   <= '0;
        end else begin
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_r     <= mul_r;
                r_res_tag   <= r_iss_tag;
            end else if (w_res_take) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign mul_valid_in = r_mul_valid_in;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign res_valid    = r_res_valid;
    assign res_r        = r_res_r;
    assign res_tag      = r_res_tag;
    assign fifo_count   = r_count;
    assign busy         = (r_state != c_ST_IDLE) || (r_count != '0);

endmodule
`default_nettype wire
